// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: 640x480@60 VGA scan engine for the object-machine video path.
// Presents col/row to the object machines, samples their hit bit at the end of
// each pixel and emits hs/vs/RGB/active one pixel later, all mutually aligned.
// Optional build macro VGA_TEST_PATTERN_EN adds an 8-bar colour test pattern
// selected by test_mode; without it test_mode is ignored.
module vga_scan_ctrl #(
  parameter int          PIX_DIV  = 4,
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic [11:0] OBJ_RGB  = 12'hF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        obj_hit,
  input  logic [11:0] bg_rgb,
  input  logic        test_mode,
  output logic [9:0]  col,
  output logic [9:0]  row,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        frame_start,
  output logic        active
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Typed 10-bit boundaries keep every counter comparison width-matched.
  localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [3:0]  div_cnt;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic        pix_tick;
  logic        line_end;
  logic        frame_end;
  logic        vis;
  logic        hs_n;
  logic        vs_n;
  logic [11:0] pix_rgb;
  logic [11:0] rgb_q;

  assign pix_tick  = (div_cnt == DIV_LAST);
  assign line_end  = (hcnt == H_LAST);
  assign frame_end = line_end && (vcnt == V_LAST);

  // Coordinates come straight from the counters so object machines see a
  // value that is stable for the whole pixel period.
  assign col = hcnt;
  assign row = vcnt;
  assign {r, g, b} = rgb_q;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_idx;
  assign bar_idx = 3'(hcnt / 10'd80);
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
`endif

  // Decode the pixel that is ending: visibility, sync levels and its colour.
  always_comb begin
    // NOTE: every always_comb output is given a default first so no path can
    // leave it unassigned and infer a latch.
    vis     = (hcnt < H_VIS) && (vcnt < V_VIS);
    hs_n    = !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
    vs_n    = !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
    pix_rgb = 12'h000;
    if (vis) begin
      pix_rgb = obj_hit ? OBJ_RGB : bg_rgb;
`ifdef VGA_TEST_PATTERN_EN
      if (test_mode) begin
        unique case (bar_idx)
          3'd0:    pix_rgb = 12'hFFF;
          3'd1:    pix_rgb = 12'hFF0;
          3'd2:    pix_rgb = 12'h0FF;
          3'd3:    pix_rgb = 12'h0F0;
          3'd4:    pix_rgb = 12'hF0F;
          3'd5:    pix_rgb = 12'hF00;
          3'd6:    pix_rgb = 12'h00F;
          default: pix_rgb = 12'h000;
        endcase
      end
`endif
    end
  end

  // Pixel divider, scan counters and the one-pixel-late output register stage.
  always_ff @(posedge clk) begin
    // NOTE: state is only a handful of flops, so everything takes the reset;
    // with nothing left stale, scanning restarts cleanly at (0,0).
    if (rst) begin
      div_cnt     <= 4'd0;
      hcnt        <= 10'd0;
      vcnt        <= 10'd0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      rgb_q       <= 12'h000;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values of the others, whatever the statement order.
      div_cnt     <= pix_tick ? 4'd0 : div_cnt + 4'd1;
      frame_start <= pix_tick && frame_end;
      if (pix_tick) begin
        hcnt   <= line_end ? 10'd0 : hcnt + 10'd1;
        if (line_end) begin
          vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end
        hs     <= hs_n;
        vs     <= vs_n;
        rgb_q  <= pix_rgb;
        active <= vis;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl. Unit A uses the full 640x480 geometry for
// line-level timing and the colour-bar pattern; unit B uses a tiny geometry
// (24x10 total, 16x6 visible) so whole frames, resets and single-pixel hits
// fit in a short run.
module tb_vga_scan_ctrl;

  localparam logic [11:0] BG_A     = 12'h00F;
  localparam logic [11:0] BG_B     = 12'h0A5;
  localparam int          HIT_P    = 53;   // unit B pixel (5,2)
  localparam int          GLITCH_P = 27;   // unit B pixel (3,1)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        test_mode = 1'b0;
  logic        obj_hit_a = 1'b1;
  logic        obj_hit_b = 1'b0;
  logic [11:0] bg_a = BG_A;
  logic [11:0] bg_b = BG_B;

  logic [9:0] col_a, row_a, col_b, row_b;
  logic       hs_a, vs_a, fs_a, active_a, hs_b, vs_b, fs_b, active_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic [15:0] obs_a, obs_b;

  int checks = 0;
  int errors = 0;

  assign obs_a = {hs_a, vs_a, active_a, fs_a, r_a, g_a, b_a};
  assign obs_b = {hs_b, vs_b, active_b, fs_b, r_b, g_b, b_b};

  always #5 clk = ~clk;

  vga_scan_ctrl u_a (
    .clk(clk), .rst(rst), .obj_hit(obj_hit_a), .bg_rgb(bg_a),
    .test_mode(test_mode), .col(col_a), .row(row_a), .hs(hs_a), .vs(vs_a),
    .r(r_a), .g(g_a), .b(b_a), .frame_start(fs_a), .active(active_a)
  );

  vga_scan_ctrl #(
    .PIX_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .OBJ_RGB(12'hF00)
  ) u_b (
    .clk(clk), .rst(rst), .obj_hit(obj_hit_b), .bg_rgb(bg_b),
    .test_mode(test_mode), .col(col_b), .row(row_b), .hs(hs_b), .vs(vs_b),
    .r(r_b), .g(g_b), .b(b_b), .frame_start(fs_b), .active(active_b)
  );

  // Expected {hs,vs,active,frame_start,rgb} of unit A at sample k (k clocks
  // after reset release); pixel p is shown on samples 4p+4..4p+7.
  function automatic logic [15:0] exp_a(int k, logic tm);
    int p, h, v;
    logic vis;
    logic [11:0] c;
    if (k < 4) return 16'hC000;
    p   = k / 4 - 1;
    h   = p % 800;
    v   = (p / 800) % 525;
    vis = (h < 640) && (v < 480);
    c   = vis ? 12'hF00 : 12'h000;   // obj_hit_a is tied high
`ifdef VGA_TEST_PATTERN_EN
    if (tm && vis) begin
      case (h / 80)
        0: c = 12'hFFF;  1: c = 12'hFF0;  2: c = 12'h0FF;  3: c = 12'h0F0;
        4: c = 12'hF0F;  5: c = 12'hF00;  6: c = 12'h00F;  default: c = 12'h000;
      endcase
    end
`else
    if (tm) c = c;
`endif
    return {!(h >= 656 && h <= 751), !(v >= 490 && v <= 491), vis,
            (k % 1680000) == 0, c};
  endfunction

  // Expected outputs of unit B; only pixel HIT_P carries a hit at pix_tick.
  function automatic logic [15:0] exp_b(int k);
    int p, h, v;
    logic vis;
    logic [11:0] c;
    if (k < 4) return 16'hC000;
    p   = k / 4 - 1;
    h   = p % 24;
    v   = (p / 24) % 10;
    vis = (h < 16) && (v < 6);
    c   = vis ? (((p % 240) == HIT_P) ? 12'hF00 : BG_B) : 12'h000;
    return {!(h >= 18 && h <= 20), !(v >= 7 && v <= 8), vis, (k % 960) == 0, c};
  endfunction

  // Drive unit B's hit for the interval after sample k: solid on HIT_P, and a
  // glitch on GLITCH_P that is high mid-pixel but low on the pix_tick clock.
  task automatic drive_b(input int k);
    int q;
    q = (k / 4) % 240;
    obj_hit_b = (q == HIT_P) || ((q == GLITCH_P) && ((k % 4) != 3) && ((k % 2) == 0));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    obj_hit_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_b(0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({col_a, row_a, obs_a} !== {20'd0, 16'hC000}) begin
      errors++;
      $display("FAIL reset_a: got col=%0d row=%0d out=%h, want 0 0 c000", col_a, row_a, obs_a);
    end
    checks++;
    if ({col_b, row_b, obs_b} !== {20'd0, 16'hC000}) begin
      errors++;
      $display("FAIL reset_b: got col=%0d row=%0d out=%h, want 0 0 c000", col_b, row_b, obs_b);
    end
  endtask

  task automatic test_line_timing();
    int hs_cnt, act_cnt, first_hs;
    hs_cnt = 0; act_cnt = 0; first_hs = -1;
    test_mode = 1'b0;
    apply_reset();
    for (int k = 1; k <= 6400; k++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== exp_a(k, 1'b0)) begin
        errors++;
        $display("FAIL line_out k=%0d: got %h want %h", k, obs_a, exp_a(k, 1'b0));
      end
      checks++;
      if ({col_a, row_a} !== {10'((k / 4) % 800), 10'(k / 3200)}) begin
        errors++;
        $display("FAIL line_coord k=%0d: got %0d,%0d want %0d,%0d", k, col_a, row_a,
                 (k / 4) % 800, k / 3200);
      end
      if (k <= 3200) begin
        if (hs_a === 1'b0) begin
          hs_cnt++;
          if (first_hs < 0) first_hs = k;
        end
        if (active_a === 1'b1) act_cnt++;
      end
      drive_b(k);
    end
    checks++;
    if (hs_cnt != 384) begin
      errors++; $display("FAIL hs_width: got %0d clks want 384", hs_cnt);
    end
    checks++;
    if (first_hs != 2628) begin
      errors++; $display("FAIL hs_start: got sample %0d want 2628", first_hs);
    end
    checks++;
    if (act_cnt != 2560) begin
      errors++; $display("FAIL active_line: got %0d clks want 2560", act_cnt);
    end
  endtask

  task automatic test_frame();
    int fs_cnt, fs_first, hit_cnt, hit_first, hs_cnt, vs_cnt, act_cnt;
    fs_cnt = 0; fs_first = -1; hit_cnt = 0; hit_first = -1;
    hs_cnt = 0; vs_cnt = 0; act_cnt = 0;
    apply_reset();
    for (int k = 1; k <= 1920; k++) begin
      @(negedge clk);
      checks++;
      if (obs_b !== exp_b(k)) begin
        errors++;
        $display("FAIL frame_out k=%0d: got %h want %h", k, obs_b, exp_b(k));
      end
      checks++;
      if ({col_b, row_b} !== {10'((k / 4) % 24), 10'((k / 96) % 10)}) begin
        errors++;
        $display("FAIL frame_coord k=%0d: got %0d,%0d want %0d,%0d", k, col_b, row_b,
                 (k / 4) % 24, (k / 96) % 10);
      end
      if (k == 113) begin
        checks++;
        if ({r_b, g_b, b_b} !== BG_B) begin
          errors++; $display("FAIL glitch_pixel: got %h want %h", {r_b, g_b, b_b}, BG_B);
        end
      end
      if (fs_b === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
      end
      if (k <= 960) begin
        if ({r_b, g_b, b_b} === 12'hF00) begin
          hit_cnt++;
          if (hit_first < 0) hit_first = k;
        end
        if (hs_b === 1'b0) hs_cnt++;
        if (vs_b === 1'b0) vs_cnt++;
        if (active_b === 1'b1) act_cnt++;
      end
      drive_b(k);
    end
    checks++;
    if (fs_first != 960) begin
      errors++; $display("FAIL frame_start_pos: got %0d want 960", fs_first);
    end
    checks++;
    if (fs_cnt != 2) begin
      errors++; $display("FAIL frame_start_cnt: got %0d want 2", fs_cnt);
    end
    checks++;
    if (hit_cnt != 4 || hit_first != 216) begin
      errors++;
      $display("FAIL single_hit: got %0d clks at %0d want 4 at 216", hit_cnt, hit_first);
    end
    checks++;
    if (hs_cnt != 120 || vs_cnt != 192 || act_cnt != 384) begin
      errors++;
      $display("FAIL frame_counts: got hs=%0d vs=%0d act=%0d want 120 192 384",
               hs_cnt, vs_cnt, act_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int fs_first, fs_cnt;
    fs_first = -1; fs_cnt = 0;
    apply_reset();
    for (int k = 1; k <= 425; k++) begin
      @(negedge clk);
      checks++;
      if (obs_b !== exp_b(k)) begin
        errors++;
        $display("FAIL pre_reset k=%0d: got %h want %h", k, obs_b, exp_b(k));
      end
      drive_b(k);
    end
    checks++;
    if ({col_b, row_b} !== {10'd10, 10'd4}) begin
      errors++; $display("FAIL pre_reset_pos: got %0d,%0d want 10,4", col_b, row_b);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({col_b, row_b, obs_b} !== {20'd0, 16'hC000}) begin
      errors++;
      $display("FAIL mid_reset: got col=%0d row=%0d out=%h want 0 0 c000", col_b, row_b, obs_b);
    end
    rst = 1'b0;
    drive_b(0);
    for (int k = 1; k <= 1920; k++) begin
      @(negedge clk);
      checks++;
      if (obs_b !== exp_b(k)) begin
        errors++;
        $display("FAIL post_reset k=%0d: got %h want %h", k, obs_b, exp_b(k));
      end
      if (fs_b === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
      end
      drive_b(k);
    end
    checks++;
    if (fs_first != 960 || fs_cnt != 2) begin
      errors++;
      $display("FAIL post_reset_frame: got first=%0d count=%0d want 960 2", fs_first, fs_cnt);
    end
  endtask

  task automatic test_pattern();
    logic [11:0] want_bar0, want_bar1, want_bar7;
`ifdef VGA_TEST_PATTERN_EN
    want_bar0 = 12'hFFF; want_bar1 = 12'hFF0; want_bar7 = 12'h000;
`else
    want_bar0 = 12'hF00; want_bar1 = 12'hF00; want_bar7 = 12'hF00;
`endif
    test_mode = 1'b1;
    apply_reset();
    for (int k = 1; k <= 3200; k++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== exp_a(k, 1'b1)) begin
        errors++;
        $display("FAIL pattern_out k=%0d: got %h want %h", k, obs_a, exp_a(k, 1'b1));
      end
      if (k == 5 || k == 325 || k == 2245) begin
        checks++;
        if ({r_a, g_a, b_a} !== ((k == 5) ? want_bar0 : (k == 325) ? want_bar1 : want_bar7)) begin
          errors++;
          $display("FAIL pattern_bar k=%0d: got %h", k, {r_a, g_a, b_a});
        end
      end
      drive_b(k);
    end
    test_mode = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_line_timing();
    test_frame();
    test_reset_mid_frame();
    test_pattern();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Display-side scan engine for the fruit-ninja video path; drives the col/row coordinates that every object machine decodes.
- Samples the per-pixel hit bit returned by the object machines and merges it with the background colour.
- Emits 640x480@60 VGA timing (hs, vs, 12-bit RGB), aligned to the sampled pixel.
- Sits between the object machines and the board VGA connector; its frame_start pulse is available to game logic as a frame tick.

Parameters:
- PIX_DIV, 4, system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate); legal range 2..16
- H_ACTIVE, 640, visible columns
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible rows
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- OBJ_RGB, 12'hF00, colour output where obj_hit=1

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous reset, active-high
- obj_hit  in  1  OR of object-machine outputdata for the current col/row
- bg_rgb  in  12  background colour {R,G,B} 4 bits each
- test_mode  in  1  colour-bar select (used only with the optional feature)
- col  out  10  current scan column to object machines
- row  out  10  current scan row to object machines
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- r  out  4  red
- g  out  4  green
- b  out  4  blue
- frame_start  out  1  one-clk pulse at frame wrap
- active  out  1  high while the emitted pixel is visible

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Totals: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- Divider: div_cnt counts 0..PIX_DIV-1 and wraps. pix_tick = (div_cnt == PIX_DIV-1).
- hcnt: increments on pix_tick; wraps H_TOTAL-1 -> 0.
- vcnt: increments on pix_tick when hcnt == H_TOTAL-1; wraps V_TOTAL-1 -> 0.
- col = hcnt and row = vcnt, driven directly from registers. Each coordinate is stable for exactly PIX_DIV clocks; object machines get PIX_DIV-1 clocks of settling.
- Sample stage, on pix_tick: capture obj_hit, hcnt and vcnt of the ending pixel, then register the outputs:
  - vis = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - {r,g,b} = vis ? (obj_hit ? OBJ_RGB : bg_rgb) : 12'h000.
  - hs = ~(hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]), i.e. low for 656..751.
  - vs = ~(vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]), i.e. low for 490..491.
  - active = vis.
- Latency: hs/vs/rgb/active lag col/row by exactly one pixel (PIX_DIV clocks). All video outputs are mutually aligned and change only on the clock after pix_tick.
- frame_start = 1 for one clk, on the clock after the pix_tick with hcnt = H_TOTAL-1 and vcnt = V_TOTAL-1. Otherwise 0.
- Reset values: div_cnt=0, hcnt=0, vcnt=0, col=0, row=0, hs=1, vs=1, r=g=b=0, active=0, frame_start=0.
- Reset mid-frame: all state returns to the reset values on the next clk. Scanning restarts at (0,0) with no partial sync pulse; no frame_start is generated by the reset itself.
- obj_hit is ignored outside the active region. An obj_hit change between pix_ticks has no effect; only the value at pix_tick is used.
- Counter widths: hcnt and vcnt are 10 bits; the parameters must satisfy H_TOTAL, V_TOTAL ≤ 1024.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: when test_mode=1, visible pixels output 8 vertical colour bars, 80 columns each, in the order FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000. Bar index = hcnt[9:0]/80, computed from the sampled hcnt. obj_hit and bg_rgb are ignored; timing is unchanged.
- Undefined: test_mode has no effect and no bar logic is synthesised.

Test Plan:
- Reset then run 1 frame -> hs low for exactly 96 pixels (384 clks) per 800-pixel line; vs low for 2 lines (1600 pixels); exactly 1 frame_start per 420000 pixels (1680000 clks).
- Tie obj_hit=1 and bg_rgb=12'h00F -> rgb=F00 for pixel (0,0) through (639,479); rgb=000 at hcnt=640..799 and vcnt=480..524; active high exactly 307200 pixels per frame.
- Drive obj_hit=1 only while col=100 and row=50 -> exactly one F00 pixel in the frame, emitted one pixel after col=100/row=50 is presented; all other visible pixels = bg_rgb.
- Toggle obj_hit mid-pixel (clocks 0..PIX_DIV-2) and hold 0 at pix_tick -> pixel shows bg_rgb; the glitch never appears on rgb.
- Assert rst for 1 clk at col=300, row=200 -> next clk col=0, row=0, hs=vs=1, rgb=0, frame_start=0; the next frame_start occurs after a full 1680000 clks.
- With VGA_TEST_PATTERN_EN and test_mode=1 -> col 0..79 = FFF, col 80..159 = FFF? no: 80..159 = FF0, col 560..639 = 000; with the macro undefined the output is identical to the test_mode=0 case.
